// File: rtl/weight_loader.sv
// Drains a coefficient stream into a KERN_SIZE-deep register bank and holds the full kernel until released.
// Optional running signed sum of the kernel is enabled by defining WEIGHT_LOADER_SUM_EN.
module weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int KERN_SIZE  = 9
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [DATA_WIDTH-1:0]           input_V_dout,
    input  logic                            input_V_empty_n,
    output logic                            input_V_read,
    output logic [KERN_SIZE*DATA_WIDTH-1:0] weights_flat,
    output logic                            weights_valid,
    input  logic                            weights_release
`ifdef WEIGHT_LOADER_SUM_EN
    ,
    output logic signed [DATA_WIDTH+$clog2(KERN_SIZE)-1:0] weights_sum
`endif
);

    localparam int IDX_W = $clog2(KERN_SIZE);

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             w_pop;
    logic             w_last;

    // Pop strobe follows empty_n combinationally so a word is taken every cycle the FIFO has one.
    assign w_pop         = (r_state == S_LOAD) && input_V_empty_n;
    assign w_last        = (r_idx == IDX_W'(KERN_SIZE - 1));
    assign input_V_read  = w_pop;
    assign weights_valid = r_valid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_pop) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_READY;
                            r_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (weights_release) begin
                        r_state <= S_LOAD;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bank is never cleared on release; a reload overwrites each slot as its word arrives.
    for (genvar k = 0; k < KERN_SIZE; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_coeff;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_coeff <= '0;
            end else if (w_pop && (r_idx == IDX_W'(k))) begin
                r_coeff <= input_V_dout;
            end
        end

        assign weights_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_coeff;
    end

`ifdef WEIGHT_LOADER_SUM_EN
    localparam int SUM_W = DATA_WIDTH + IDX_W;

    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_dout_ext;

    assign w_dout_ext  = {{(SUM_W-DATA_WIDTH){input_V_dout[DATA_WIDTH-1]}}, input_V_dout};
    assign weights_sum = r_sum;

    // Cleared on every entry into LOAD so the next kernel starts from zero.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_sum <= '0;
        end else if ((r_state == S_READY) && weights_release) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + w_dout_ext;
        end
    end
`endif

endmodule
